// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq.sv
// Switchable decap bank sequencer: ramps N_SEG header-switched fillcap
// segments on/off one at a time, STEP_CYC clocks apart, to bound inrush.
//
// Ports:
//   CLK    in     rising-edge clock
//   RN     in     asynchronous active-low reset
//   VDD    inout  power rail (pass-through, not used by logic)
//   VSS    inout  ground rail (pass-through, not used by logic)
//   EN_REQ in     level request, 1 = bank on, 0 = bank off
//   SEL    in     segments taking part, sampled when leaving OFF
//   SEG_EN out    per-segment header switch enable
//   READY  out    all selected segments on and settled
//   BUSY   out    ramp up or ramp down in progress
module gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(
    parameter int N_SEG    = 8,
    parameter int STEP_CYC = 4
) (
    input  logic             CLK,
    input  logic             RN,
    inout  wire              VDD,
    inout  wire              VSS,
    input  logic             EN_REQ,
    input  logic [N_SEG-1:0] SEL,
    output logic [N_SEG-1:0] SEG_EN,
    output logic             READY,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        S_OFF,
        S_UP,
        S_ON,
        S_DOWN
    } state_t;

    localparam logic [7:0]       LAST = 8'(STEP_CYC - 1);
    localparam logic [N_SEG-1:0] ONE  = N_SEG'(1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_SEG-1:0] mask_q, mask_d;
    logic [N_SEG-1:0] seg_q, seg_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [N_SEG-1:0] pending;
    logic [N_SEG-1:0] up_bit;
    logic [N_SEG-1:0] dn_bit;
    logic [N_SEG-1:0] lo_sel;
    logic [N_SEG-1:0] seg_dn;
    logic             step;

    wire unused_rails = VDD ^ VSS;

    // Enabled segments are always the lowest-order set bits of the mask,
    // so the next one up is the lowest still-pending mask bit and the
    // next one down is the highest enabled bit.
    assign pending = mask_q & ~seg_q;
    assign up_bit  = pending & (~pending + ONE);
    assign lo_sel  = SEL & (~SEL + ONE);
    assign seg_dn  = seg_q & ~dn_bit;
    assign step    = (cnt_q == LAST);

    always_comb begin
        dn_bit = '0;
        for (int i = 0; i < N_SEG; i++) begin
            if (seg_q[i]) begin
                dn_bit    = '0;
                dn_bit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        seg_d   = seg_q;
        unique case (state_q)
            S_OFF: begin
                if (EN_REQ) begin
                    mask_d  = SEL;
                    seg_d   = lo_sel;
                    cnt_d   = '0;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                if (!EN_REQ) begin
                    seg_d   = seg_dn;
                    cnt_d   = '0;
                    state_d = (seg_dn == '0) ? S_OFF : S_DOWN;
                end else if (step) begin
                    cnt_d = '0;
                    // Nothing left to switch: this step was the settle wait.
                    if (up_bit == '0) begin
                        state_d = S_ON;
                    end else begin
                        seg_d = seg_q | up_bit;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ON: begin
                if (!EN_REQ) begin
                    seg_d   = seg_dn;
                    cnt_d   = '0;
                    state_d = (seg_dn == '0) ? S_OFF : S_DOWN;
                end
            end
            S_DOWN: begin
                if (EN_REQ) begin
                    seg_d   = seg_q | up_bit;
                    cnt_d   = '0;
                    state_d = S_UP;
                end else if (step) begin
                    seg_d   = seg_dn;
                    cnt_d   = '0;
                    if (seg_dn == '0) begin
                        state_d = S_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_OFF;
                seg_d   = '0;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == S_ON);
        busy_d  = (state_d == S_UP) || (state_d == S_DOWN);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            mask_q  <= '0;
            seg_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            seg_q   <= seg_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign SEG_EN = seg_q;
    assign READY  = ready_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq.sv
// Directed bench for the decap bank sequencer: ramp up/down, sparse
// select, reversal, async reset, empty select and a STEP_CYC=1 sweep.
module tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq;

    logic       clk = 1'b0;
    logic       rn  = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] sel = 8'h00;
    logic [7:0] seg;
    logic       ready;
    logic       busy;

    logic       en2  = 1'b0;
    logic [7:0] sel2 = 8'h00;
    logic [7:0] seg2;
    logic       ready2;
    logic       busy2;

    wire vdd;
    wire vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(
        .N_SEG   (8),
        .STEP_CYC(4)
    ) dut (
        .CLK   (clk),
        .RN    (rn),
        .VDD   (vdd),
        .VSS   (vss),
        .EN_REQ(en),
        .SEL   (sel),
        .SEG_EN(seg),
        .READY (ready),
        .BUSY  (busy)
    );

    gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_seq #(
        .N_SEG   (8),
        .STEP_CYC(1)
    ) dut1 (
        .CLK   (clk),
        .RN    (rn),
        .VDD   (vdd),
        .VSS   (vss),
        .EN_REQ(en2),
        .SEL   (sel2),
        .SEG_EN(seg2),
        .READY (ready2),
        .BUSY  (busy2)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep [5];

    initial begin
        sweep[0] = 8'h02;
        sweep[1] = 8'h0A;
        sweep[2] = 8'h1A;
        sweep[3] = 8'h5A;
        sweep[4] = 8'h5A;

        // reset state
        #12;
        check("rst_seg", seg, 0);
        check("rst_rdy", ready, 0);
        check("rst_busy", busy, 0);
        rn = 1'b1;
        tick();
        check("idle_seg", seg, 0);

        // full ramp up, SEL=FF
        sel = 8'hFF;
        en  = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            tick();
            check("up_seg", seg,
                  (e < 32) ? ((32'd1 << (e / 4 + 1)) - 1) : 32'hFF);
            check("up_busy", busy, 32'(e < 32));
            check("up_rdy", ready, 32'(e >= 32));
        end

        // full ramp down
        en = 1'b0;
        for (int e = 0; e <= 28; e++) begin
            tick();
            check("dn_seg", seg, 32'hFF >> (e / 4 + 1));
            check("dn_busy", busy, 32'(e < 28));
            check("dn_rdy", ready, 0);
        end

        // sparse select A4
        sel = 8'hA4;
        en  = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check("a4_seg", seg,
                  (e < 4) ? 32'h04 : (e < 8) ? 32'h24 : 32'hA4);
            check("a4_out", seg & 8'h5B, 0);
            check("a4_rdy", ready, 32'(e >= 12));
        end
        en = 1'b0;
        for (int e = 0; e <= 8; e++) tick();
        check("a4_off_seg", seg, 0);
        check("a4_off_busy", busy, 0);

        // reversal mid-ramp
        sel = 8'hFF;
        en  = 1'b1;
        for (int e = 0; e <= 8; e++) tick();
        check("rev_e8", seg, 8'h07);
        en = 1'b0;
        tick();
        check("rev_e9", seg, 8'h03);
        check("rev_e9_busy", busy, 1);
        for (int e = 10; e <= 13; e++) tick();
        check("rev_e13", seg, 8'h01);
        en  = 1'b1;
        sel = 8'h00;
        tick();
        check("rev_e14", seg, 8'h03);
        for (int e = 15; e <= 17; e++) tick();
        check("rev_e17", seg, 8'h03);
        tick();
        check("rev_e18", seg, 8'h07);
        for (int e = 19; e <= 22; e++) tick();
        check("rev_e22", seg, 8'h0F);

        // async reset mid-ramp
        #1 rn = 1'b0;
        #1;
        check("arst_seg", seg, 0);
        check("arst_rdy", ready, 0);
        check("arst_busy", busy, 0);
        sel = 8'h30;
        #1 rn = 1'b1;
        tick();
        check("rst_up_e0", seg, 8'h10);
        check("rst_up_busy", busy, 1);
        for (int e = 1; e <= 4; e++) tick();
        check("rst_up_e4", seg, 8'h30);
        for (int e = 5; e <= 8; e++) tick();
        check("rst_up_rdy", ready, 1);
        check("rst_up_nbusy", busy, 0);
        en = 1'b0;
        tick();
        check("rst_dn_e0", seg, 8'h10);
        for (int e = 1; e <= 4; e++) tick();
        check("rst_dn_e4", seg, 0);
        check("rst_dn_busy", busy, 0);

        // empty select
        sel = 8'h00;
        en  = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            check("sel0_seg", seg, 0);
            check("sel0_busy", busy, 32'(e < 4));
            check("sel0_rdy", ready, 32'(e >= 4));
        end
        en = 1'b0;
        tick();
        check("sel0_off_busy", busy, 0);
        check("sel0_off_rdy", ready, 0);
        check("sel0_off_seg", seg, 0);

        // STEP_CYC=1 sweep, SEL=5A (M=4)
        sel2 = 8'h5A;
        en2  = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            check("s1_seg", seg2, sweep[e]);
            check("s1_busy", busy2, 32'(e < 4));
            check("s1_rdy", ready2, 32'(e >= 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
